// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encoding, grant codes and defaults for the bus arbiter
package mem_bus_arbiter_pkg;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CPU_BUS  = 3'd1;
  localparam logic [2:0] ST_CPU_DONE = 3'd2;
  localparam logic [2:0] ST_DMA_BUS  = 3'd3;
  localparam logic [2:0] ST_DMA_DONE = 3'd4;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DMA  = 2'b10;
  localparam logic [31:0] DEAD_DATA_DEFAULT = 32'hDEADBEEF;
  function automatic logic [1:0] grant_of(input logic [2:0] st);
    return (st == ST_CPU_BUS || st == ST_CPU_DONE) ? GRANT_CPU :
           (st == ST_DMA_BUS || st == ST_DMA_DONE) ? GRANT_DMA : GRANT_NONE;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, DMA and memory-bus signals around the arbiter
interface mem_bus_arbiter_if;
  logic [31:0] iCpuAddress;
  logic [31:0] iCpuWriteData;
  logic        iCpuWriteEnable;
  logic        iCpuReadEnable;
  logic [3:0]  iCpuByteEnable;
  logic [31:0] oCpuReadData;
  logic        oCpuStall;
  logic        iDmaReq;
  logic        iDmaWrite;
  logic [31:0] iDmaAddress;
  logic [31:0] iDmaWriteData;
  logic [3:0]  iDmaByteEnable;
  logic [31:0] oDmaReadData;
  logic        oDmaDone;
  logic [31:0] oAddress;
  logic [31:0] oWriteData;
  logic        oWriteEnable;
  logic        oReadEnable;
  logic [3:0]  oByteEnable;
  logic [31:0] iReadData;
  logic        iReady;
  logic        oTimeout;
  logic [1:0]  oGrant;
  modport master (
    input  iCpuAddress, iCpuWriteData, iCpuWriteEnable, iCpuReadEnable, iCpuByteEnable,
    input  iDmaReq, iDmaWrite, iDmaAddress, iDmaWriteData, iDmaByteEnable,
    input  iReadData, iReady,
    output oCpuReadData, oCpuStall, oDmaReadData, oDmaDone,
    output oAddress, oWriteData, oWriteEnable, oReadEnable, oByteEnable, oTimeout, oGrant
  );
  modport slave (
    output iCpuAddress, iCpuWriteData, iCpuWriteEnable, iCpuReadEnable, iCpuByteEnable,
    output iDmaReq, iDmaWrite, iDmaAddress, iDmaWriteData, iDmaByteEnable,
    output iReadData, iReady,
    input  oCpuReadData, oCpuStall, oDmaReadData, oDmaDone,
    input  oAddress, oWriteData, oWriteEnable, oReadEnable, oByteEnable, oTimeout, oGrant
  );
endinterface

// File: rtl/mem_bus_arbiter_bus_wait_timer.sv
// mem_bus_arbiter_bus_wait_timer: saturating count of slave wait cycles with expiry flag
module mem_bus_arbiter_bus_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClear,
  input  logic iEnable,
  output logic oExpired
);
  logic [7:0] cnt_q, cnt_d;
  // clear wins over counting; the count sticks at 255 instead of wrapping
  always_comb cnt_d = iClear ? 8'd0 : (iEnable && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  // counter register
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign oExpired = cnt_q == 8'(MAX_WAIT);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory bus between CPU and DMA with wait timeout
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int          MAX_WAIT  = 16,
  parameter logic [31:0] DEAD_DATA = DEAD_DATA_DEFAULT
) (
  input logic               iCLK,
  input logic               iRST,
  mem_bus_arbiter_if.master bus
);
  logic [2:0]  state_q, state_d;
  logic        last_dma_q, last_dma_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d, re_q, re_d, timeout_q, timeout_d;
  logic        cpu_req, pick_cpu, in_bus, is_cpu, expired;
  logic [31:0] cap;
  assign cpu_req  = bus.iCpuReadEnable | bus.iCpuWriteEnable;
  assign pick_cpu = cpu_req & (~bus.iDmaReq | last_dma_q);
  assign in_bus   = (state_q == ST_CPU_BUS) | (state_q == ST_DMA_BUS);
  assign is_cpu   = state_q == ST_CPU_BUS;
  assign cap      = bus.iReady ? bus.iReadData : DEAD_DATA;
  mem_bus_arbiter_bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iClear   (~in_bus),
    .iEnable  (in_bus & ~bus.iReady),
    .oExpired (expired)
  );
  // grant selection, bus register loading, completion and abort handling
  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    re_d        = re_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        we_d = 1'b0;
        re_d = 1'b0;
        if (pick_cpu) begin
          state_d = ST_CPU_BUS;
          addr_d  = bus.iCpuAddress;
          wdata_d = bus.iCpuWriteData;
          be_d    = bus.iCpuByteEnable;
          we_d    = bus.iCpuWriteEnable;
          re_d    = ~bus.iCpuWriteEnable;
        end else if (bus.iDmaReq) begin
          state_d = ST_DMA_BUS;
          addr_d  = bus.iDmaAddress;
          wdata_d = bus.iDmaWriteData;
          be_d    = bus.iDmaByteEnable;
          we_d    = bus.iDmaWrite;
          re_d    = ~bus.iDmaWrite;
        end
      end
      ST_CPU_BUS, ST_DMA_BUS: begin
        if (bus.iReady | expired) begin
          state_d   = is_cpu ? ST_CPU_DONE : ST_DMA_DONE;
          we_d      = 1'b0;
          re_d      = 1'b0;
          timeout_d = ~bus.iReady;
          if (~bus.iReady | re_q) begin
            if (is_cpu) cpu_rdata_d = cap;
            else dma_rdata_d = cap;
          end
        end
      end
      ST_CPU_DONE: begin
        state_d    = ST_IDLE;
        last_dma_d = 1'b0;
      end
      ST_DMA_DONE: begin
        state_d    = ST_IDLE;
        last_dma_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and bus registers; reset drops strobes immediately and favours the CPU on the first tie
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      last_dma_q  <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      re_q        <= re_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      timeout_q   <= timeout_d;
    end
  end
  assign bus.oAddress     = addr_q;
  assign bus.oWriteData   = wdata_q;
  assign bus.oByteEnable  = be_q;
  assign bus.oWriteEnable = we_q;
  assign bus.oReadEnable  = re_q;
  assign bus.oCpuReadData = cpu_rdata_q;
  assign bus.oDmaReadData = dma_rdata_q;
  assign bus.oTimeout     = timeout_q;
  assign bus.oDmaDone     = state_q == ST_DMA_DONE;
  assign bus.oCpuStall    = cpu_req & (state_q != ST_CPU_DONE);
  assign bus.oGrant       = grant_of(state_q);
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Sequences the single shared data/instruction memory bus between the multicycle RISC-V datapath (master 0, CPU) and a DMA/debug requester (master 1, e.g. VGA or loader).
Sits between the datapath's Dw* bus signals and the memory/peripheral bus.
Stalls the CPU's control FSM until its access completes.
Enforces round-robin fairness and a bus-wait timeout.

Parameters:
MAX_WAIT, 16, max cycles a granted transfer may wait for iReady before abort (1..255)
DEAD_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
iCLK  in  1  system clock, all state on rising edge
iRST  in  1  asynchronous reset, active-high
iCpuAddress  in  32  CPU byte address
iCpuWriteData  in  32  CPU store data
iCpuWriteEnable  in  1  CPU write request (level)
iCpuReadEnable  in  1  CPU read request (level)
iCpuByteEnable  in  4  CPU byte lanes
oCpuReadData  out  32  registered read data for CPU
oCpuStall  out  1  CPU must hold control state and registers
iDmaReq  in  1  DMA request (level, held until oDmaDone)
iDmaWrite  in  1  1=write, 0=read
iDmaAddress  in  32  DMA address
iDmaWriteData  in  32  DMA store data
iDmaByteEnable  in  4  DMA byte lanes
oDmaReadData  out  32  registered read data for DMA
oDmaDone  out  1  one-cycle completion pulse
oAddress  out  32  bus address (registered)
oWriteData  out  32  bus write data (registered)
oWriteEnable  out  1  bus write strobe (registered)
oReadEnable  out  1  bus read strobe (registered)
oByteEnable  out  4  bus byte lanes (registered)
iReadData  in  32  bus read data, valid when iReady
iReady  in  1  slave completes current transfer this cycle
oTimeout  out  1  one-cycle pulse on aborted transfer
oGrant  out  2  current owner: 00 none, 01 CPU, 10 DMA

Behaviour:
- Reset: state IDLE; all outputs 0 except oCpuStall, which follows its equation; last-grant flag = DMA, so the CPU wins the first tie.
- cpu_req = iCpuReadEnable | iCpuWriteEnable; if both asserted, write wins.
- FSM states IDLE, CPU_BUS, CPU_DONE, DMA_BUS, DMA_DONE:
- IDLE: one requester -> grant it. Both -> grant the master not granted last. On grant, latch address, data, byte enables and strobes into the o* bus registers; go to CPU_BUS or DMA_BUS. None -> stay, strobes 0.
- CPU_BUS / DMA_BUS: bus registers held stable. iReady=1 -> capture iReadData (reads only) into oCpuReadData or oDmaReadData, clear strobes, go to *_DONE. Wait counter reaches MAX_WAIT without iReady -> clear strobes, load DEAD_DATA into the read register, pulse oTimeout, go to *_DONE.
- CPU_DONE: oCpuStall=0, last-grant=CPU, go to IDLE.
- DMA_DONE: oDmaDone=1, last-grant=DMA, go to IDLE.
- oCpuStall = cpu_req & (state != CPU_DONE), combinational.
- Latency with iReady immediately high: 3 cycles (IDLE, BUS, DONE); each extra slave wait cycle adds 1.
- The wait counter clears on entry to a *_BUS state. It counts cycles in BUS with iReady=0 and saturates.
- iReady in IDLE or DONE is ignored.
- A request dropped mid-transfer does not abort; the transfer completes. For the CPU, oCpuStall then reads 0.
- The DMA must hold iDmaReq until oDmaDone. If iDmaReq is still high in the cycle after oDmaDone, it counts as a new request.
- iRST mid-transfer returns to IDLE immediately and drops strobes asynchronously; no completion or timeout pulse.
- oGrant reflects state: 01 in CPU_*, 10 in DMA_*, 00 in IDLE.

Decomposition:
- Shared package: state encoding constants (ST_IDLE..ST_DMA_DONE, 3 bits), GRANT_* codes, default DEAD_DATA.
- One sub-module: bus_wait_timer. Clear/enable inputs, saturating 8-bit counter, oExpired when count == MAX_WAIT.

Test Plan:
- CPU read 0x00400000 alone, iReady high at first BUS cycle, iReadData=0x12345678 -> oCpuStall high 2 cycles then low 1 cycle; oCpuReadData=0x12345678.
- CPU write 0x10010004, data 0xCAFEF00D, BE=0011, slave 3 wait cycles -> oWriteEnable held 4 cycles with stable address/data/BE; stall 5 cycles.
- CPU and DMA request together from reset -> CPU first. Then, with both still requesting, DMA next, then CPU; oGrant sequence 01,10,01.
- DMA read, iReady never asserted, MAX_WAIT=16 -> oTimeout and oDmaDone pulse after 16 wait cycles; oDmaReadData=0xDEADBEEF; state IDLE.
- iRST asserted in DMA_BUS -> strobes 0 before the next edge; oDmaDone never pulses; the pending CPU request is granted first after reset.
- CPU request deasserted during CPU_BUS -> transfer completes on iReady; oCpuStall 0 from deassert onward.
